dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/risc_pkg.sv | 33 +++
 rtl/dmem_arbiter_rr_arb2.sv | 16 +
 rtl/dmem_arbiter.sv | 103 ++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared types for the data-memory path: access sizes, the arbiter FSM state and
// the command captured at grant time.
package risc_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } mem_size_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } dmem_arb_state_t;

    typedef struct packed {
        logic        wr_en;
        mem_size_t   size;
        logic [31:0] addr;
        logic [31:0] wr_data;
        logic        zero_extend;
    } dmem_cmd_t;

    // Natural alignment: halfwords on even bytes, words on 4-byte boundaries.
    function automatic logic misaligned(input mem_size_t size, input logic [1:0] low);
        case (size)
            HALF_WORD: return low[0];
            WORD:      return low != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a sole requester wins; on a tie the master that was
// not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the core LSU (master 0) and the
// DMA/debug master (master 1): grant, one access cycle, then a registered response.
module dmem_arbiter
    import risc_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [1:0]            m_req,
    input  logic [1:0]            m_wr_en,
    input  logic [1:0]            m_zero_extend,
    input  mem_size_t [1:0]       m_size,
    input  logic [1:0][31:0]      m_addr,
    input  logic [1:0][31:0]      m_wr_data,
    output logic [1:0]            m_gnt,
    output logic [1:0]            m_rvalid,
    output logic [1:0]            m_err,
    output logic [31:0]           m_rdata,

    output logic                  dmem_req,
    output logic                  dmem_wr_en,
    output logic                  dmem_zero_extend,
    output mem_size_t             dmem_data_size,
    output logic [31:0]           dmem_addr,
    output logic [31:0]           dmem_wr_data,
    input  logic [31:0]           dmem_rd_data
);

    dmem_arb_state_t state;
    dmem_cmd_t       cmd;
    logic            last_gnt;
    logic [1:0]      arb_gnt;
    logic            gnt_idx;
    logic            cmd_illegal;
    logic            issue;
    logic [1:0]      owner_oh;

    function automatic logic out_of_range(input logic [31:0] addr);
        return (addr >> ADDR_WIDTH) != 32'd0;
    endfunction

    rr_arb2 u_rr_arb2 (
        .req  (m_req),
        .last (last_gnt),
        .gnt  (arb_gnt)
    );

    assign m_gnt   = (state == IDLE) ? arb_gnt : 2'b00;
    assign gnt_idx = arb_gnt[1];

    // last_gnt only moves on a grant, so during ACCESS it names the command owner.
    assign owner_oh    = last_gnt ? 2'b10 : 2'b01;
    assign cmd_illegal = misaligned(cmd.size, cmd.addr[1:0]) || out_of_range(cmd.addr);
    assign issue       = (state == ACCESS) && !cmd_illegal;

    // Memory port is gated by state, so an asynchronous reset silences it at once.
    assign dmem_req         = issue;
    assign dmem_wr_en       = issue ? cmd.wr_en       : 1'b0;
    assign dmem_zero_extend = issue ? cmd.zero_extend : 1'b0;
    assign dmem_data_size   = issue ? cmd.size        : BYTE;
    assign dmem_addr        = issue ? cmd.addr        : 32'd0;
    assign dmem_wr_data     = issue ? cmd.wr_data     : 32'd0;

    always_ff @(posedge clk) begin
        if (state == IDLE && m_req != 2'b00) begin
            cmd <= '{wr_en:       m_wr_en[gnt_idx],
                     size:        m_size[gnt_idx],
                     addr:        m_addr[gnt_idx],
                     wr_data:     m_wr_data[gnt_idx],
                     zero_extend: m_zero_extend[gnt_idx]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            m_rvalid <= 2'b00;
            m_err    <= 2'b00;
            m_rdata  <= 32'd0;
        end else begin
            m_rvalid <= 2'b00;
            case (state)
                IDLE: begin
                    if (m_req != 2'b00) begin
                        state    <= ACCESS;
                        last_gnt <= gnt_idx;
                    end
                end
                ACCESS: begin
                    state    <= IDLE;
                    m_rvalid <= owner_oh;
                    m_err    <= cmd_illegal ? owner_oh : 2'b00;
                    m_rdata  <= (cmd_illegal || cmd.wr_en) ? 32'd0 : dmem_rd_data;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model behind it.
module tb_dmem_arbiter;
    import risc_pkg::*;

    logic             clk;
    logic             rst;
    logic [1:0]       m_req;
    logic [1:0]       m_wr_en;
    logic [1:0]       m_zero_extend;
    mem_size_t [1:0]  m_size;
    logic [1:0][31:0] m_addr;
    logic [1:0][31:0] m_wr_data;
    logic [1:0]       m_gnt;
    logic [1:0]       m_rvalid;
    logic [1:0]       m_err;
    logic [31:0]      m_rdata;
    logic             dmem_req;
    logic             dmem_wr_en;
    logic             dmem_zero_extend;
    mem_size_t        dmem_data_size;
    logic [31:0]      dmem_addr;
    logic [31:0]      dmem_wr_data;
    logic [31:0]      dmem_rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter #(.ADDR_WIDTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .m_req            (m_req),
        .m_wr_en          (m_wr_en),
        .m_zero_extend    (m_zero_extend),
        .m_size           (m_size),
        .m_addr           (m_addr),
        .m_wr_data        (m_wr_data),
        .m_gnt            (m_gnt),
        .m_rvalid         (m_rvalid),
        .m_err            (m_err),
        .m_rdata          (m_rdata),
        .dmem_req         (dmem_req),
        .dmem_wr_en       (dmem_wr_en),
        .dmem_zero_extend (dmem_zero_extend),
        .dmem_data_size   (dmem_data_size),
        .dmem_addr        (dmem_addr),
        .dmem_wr_data     (dmem_wr_data),
        .dmem_rd_data     (dmem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian data memory with combinational, size/extension-aware reads.
    logic [7:0]  mem [0:65535];
    logic [15:0] ra;
    logic [7:0]  b0, b1, b2, b3;

    always_comb begin
        ra = dmem_addr[15:0];
        b0 = mem[ra];
        b1 = mem[ra + 16'd1];
        b2 = mem[ra + 16'd2];
        b3 = mem[ra + 16'd3];
        case (dmem_data_size)
            BYTE:      dmem_rd_data = dmem_zero_extend ? {24'd0, b0} : {{24{b0[7]}}, b0};
            HALF_WORD: dmem_rd_data = dmem_zero_extend ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default:   dmem_rd_data = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (dmem_req && dmem_wr_en) begin
            mem[dmem_addr[15:0]] <= dmem_wr_data[7:0];
            if (dmem_data_size != BYTE)
                mem[dmem_addr[15:0] + 16'd1] <= dmem_wr_data[15:8];
            if (dmem_data_size == WORD) begin
                mem[dmem_addr[15:0] + 16'd2] <= dmem_wr_data[23:16];
                mem[dmem_addr[15:0] + 16'd3] <= dmem_wr_data[31:24];
            end
        end
    end

    typedef struct {
        logic        mi;
        logic        wr;
        mem_size_t   sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        zext;
        logic        exp_req;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic mi, input logic wr, input mem_size_t sz,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic zext, input logic exp_err,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.mi = mi; v.wr = wr; v.sz = sz; v.addr = addr; v.wdata = wdata; v.zext = zext;
        v.exp_req = !exp_err; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mi, input logic wr, input mem_size_t sz,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic zext);
        m_wr_en[mi]       = wr;
        m_size[mi]        = sz;
        m_addr[mi]        = addr;
        m_wr_data[mi]     = wdata;
        m_zero_extend[mi] = zext;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [1:0] oh;
        oh = v.mi ? 2'b10 : 2'b01;
        @(negedge clk);
        drive(v.mi, v.wr, v.sz, v.addr, v.wdata, v.zext);
        m_req = oh;
        #1;
        chk($sformatf("v%0d gnt", idx), 32'(m_gnt), 32'(oh));
        @(negedge clk);
        m_req = 2'b00;
        #1;
        chk($sformatf("v%0d dmem_req", idx), 32'(dmem_req), 32'(v.exp_req));
        chk($sformatf("v%0d rvalid_early", idx), 32'(m_rvalid), 32'd0);
        if (v.exp_req) begin
            chk($sformatf("v%0d dmem_addr", idx), dmem_addr, v.addr);
            chk($sformatf("v%0d dmem_wr_en", idx), 32'(dmem_wr_en), 32'(v.wr));
            chk($sformatf("v%0d dmem_wr_data", idx), dmem_wr_data, v.wdata);
            chk($sformatf("v%0d dmem_size", idx), 32'(dmem_data_size), 32'(v.sz));
            chk($sformatf("v%0d dmem_zext", idx), 32'(dmem_zero_extend), 32'(v.zext));
        end else begin
            chk($sformatf("v%0d dmem_addr_zero", idx), dmem_addr, 32'd0);
        end
        @(negedge clk);
        #1;
        chk($sformatf("v%0d rvalid", idx), 32'(m_rvalid), 32'(oh));
        chk($sformatf("v%0d err", idx), 32'(m_err), v.exp_err ? 32'(oh) : 32'd0);
        chk($sformatf("v%0d rdata", idx), m_rdata, v.exp_rdata);
    endtask

    vec_t vecs [17];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g [8];

        vecs[0]  = mk(1'b0, 1'b1, WORD,      32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 1'b0, WORD,      32'h0000_0100, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF);
        vecs[2]  = mk(1'b1, 1'b1, BYTE,      32'h0000_0200, 32'h0000_0080, 1'b0, 1'b0, 32'h0);
        vecs[3]  = mk(1'b1, 1'b0, BYTE,      32'h0000_0200, 32'h0,         1'b0, 1'b0, 32'hFFFF_FF80);
        vecs[4]  = mk(1'b0, 1'b0, BYTE,      32'h0000_0200, 32'h0,         1'b1, 1'b0, 32'h0000_0080);
        vecs[5]  = mk(1'b1, 1'b0, HALF_WORD, 32'h0000_0003, 32'h0,         1'b0, 1'b1, 32'h0);
        vecs[6]  = mk(1'b1, 1'b0, WORD,      32'h0000_0002, 32'h0,         1'b0, 1'b1, 32'h0);
        vecs[7]  = mk(1'b1, 1'b0, BYTE,      32'h0001_0000, 32'h0,         1'b0, 1'b1, 32'h0);
        vecs[8]  = mk(1'b0, 1'b1, HALF_WORD, 32'h0000_0102, 32'h0000_CAFE, 1'b0, 1'b0, 32'h0);
        vecs[9]  = mk(1'b0, 1'b0, WORD,      32'h0000_0100, 32'h0,         1'b0, 1'b0, 32'hCAFE_BEEF);
        vecs[10] = mk(1'b1, 1'b0, HALF_WORD, 32'h0000_0102, 32'h0,         1'b0, 1'b0, 32'hFFFF_CAFE);
        vecs[11] = mk(1'b1, 1'b1, WORD,      32'h0000_0101, 32'h1111_1111, 1'b0, 1'b1, 32'h0);
        vecs[12] = mk(1'b0, 1'b0, WORD,      32'h0000_0100, 32'h0,         1'b0, 1'b0, 32'hCAFE_BEEF);
        vecs[13] = mk(1'b0, 1'b1, WORD,      32'h0000_FFFC, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0);
        vecs[14] = mk(1'b1, 1'b0, WORD,      32'h0000_FFFC, 32'h0,         1'b0, 1'b0, 32'hA5A5_5A5A);
        vecs[15] = mk(1'b0, 1'b1, WORD,      32'h0000_0300, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
        vecs[16] = mk(1'b1, 1'b0, BYTE,      32'h0000_0300, 32'h0,         1'b1, 1'b0, 32'h0000_000D);

        rst = 1'b1;
        m_req = 2'b00;
        m_wr_en = 2'b00;
        m_zero_extend = 2'b00;
        m_size = {BYTE, BYTE};
        m_addr = '0;
        m_wr_data = '0;

        #12;
        chk("reset gnt", 32'(m_gnt), 32'd0);
        chk("reset rvalid", 32'(m_rvalid), 32'd0);
        chk("reset err", 32'(m_err), 32'd0);
        chk("reset rdata", m_rdata, 32'd0);
        chk("reset dmem_req", 32'(dmem_req), 32'd0);
        chk("reset dmem_addr", dmem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // Reset in the middle of an ACCESS store must cancel it.
        @(negedge clk);
        drive(1'b0, 1'b1, WORD, 32'h0000_0300, 32'h1234_5678, 1'b0);
        m_req = 2'b01;
        #1;
        chk("rstacc gnt", 32'(m_gnt), 32'h1);
        @(negedge clk);
        m_req = 2'b00;
        #1;
        chk("rstacc dmem_req_before", 32'(dmem_req), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstacc dmem_req", 32'(dmem_req), 32'd0);
        chk("rstacc dmem_wr_en", 32'(dmem_wr_en), 32'd0);
        chk("rstacc dmem_addr", dmem_addr, 32'd0);
        chk("rstacc dmem_wr_data", dmem_wr_data, 32'd0);
        chk("rstacc rvalid", 32'(m_rvalid), 32'd0);
        chk("rstacc rdata", m_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, WORD, 32'h0000_0300, 32'h0, 1'b0);
        drive(1'b1, 1'b0, WORD, 32'h0000_0100, 32'h0, 1'b0);
        m_req = 2'b11;
        #1;
        chk("rstacc tie_gnt", 32'(m_gnt), 32'h1);
        chk("rstacc no_rvalid", 32'(m_rvalid), 32'd0);
        @(negedge clk);
        m_req = 2'b00;
        @(negedge clk);
        #1;
        chk("rstacc reload_rvalid", 32'(m_rvalid), 32'h1);
        chk("rstacc no_write", m_rdata, 32'h0BAD_F00D);

        // Continuous tie from the first cycle after reset: grants alternate 0,1,0,1.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_req = 2'b11;
        for (int k = 0; k < 8; k++) begin
            exp_g[k] = (k % 2 == 1) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
            #1;
            chk($sformatf("rr gnt c%0d", k), 32'(m_gnt), 32'(exp_g[k]));
            if (k >= 2)
                chk($sformatf("rr rvalid c%0d", k), 32'(m_rvalid), 32'(exp_g[k-2]));
            @(negedge clk);
        end
        m_req = 2'b00;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
